// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: control FSM for an SPI slave datapath plus the register bank it shares with a host port.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   spi_read_en_out/_write_en  level requests from the SPI slave (edge detected here)
//   spi_rd_addr, spi_wr_addr   SPI read / write register addresses
//   driver_out_data            SPI write data
//   driver_in_data             SPI read data, valid with the spi_read_en_in load strobe
//   spi_frame_rst              frame-rearm reset back into the slave
//   host_req/we/addr/wdata     host request, held until host_ack
//   host_ack, host_rdata       host completion pulse and read data (held until the next ack)
//   frame_count, ro_err        committed SPI frame count, sticky read-only write error
module spi_reg_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RST_CYCLES = 2,
    parameter logic [(1<<ADDR_WIDTH)-1:0] RO_MASK = 16'h0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_read_en_out,
    input  logic                  spi_write_en_out,
    input  logic [ADDR_WIDTH-1:0] spi_rd_addr,
    input  logic [ADDR_WIDTH-1:0] spi_wr_addr,
    input  logic [DATA_WIDTH-1:0] driver_out_data,
    output logic [DATA_WIDTH-1:0] driver_in_data,
    output logic                  spi_read_en_in,
    output logic                  spi_frame_rst,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [15:0]           frame_count,
    output logic                  ro_err
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [2:0] IDLE = 3'd0, SPI_RD = 3'd1, SPI_WR = 3'd2, FRAME_RST = 3'd3, HOST = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rd_prev_q, wr_prev_q;
    logic                  rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic [DATA_WIDTH-1:0] bank_q [NREG];
    logic [DATA_WIDTH-1:0] bank_d [NREG];
    logic [DATA_WIDTH-1:0] driver_in_data_q, driver_in_data_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  rd_stb_q, rd_stb_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic                  ro_err_q, ro_err_d;
    logic                  in_rd, in_wr;

    assign in_rd = state_q == SPI_RD;
    assign in_wr = state_q == SPI_WR;
    // Ack and host read data are combinational in the HOST cycle so the host can drop req before IDLE samples it.
    assign host_ack = (state_q == HOST) && !reset;
    assign host_rdata = host_rdata_d;
    assign spi_frame_rst = reset || state_q == FRAME_RST;
    assign spi_read_en_in = rd_stb_q;
    assign driver_in_data = driver_in_data_q;
    assign frame_count = frame_count_q;
    assign ro_err = ro_err_q;

    always_comb begin
        // A new rising edge in the servicing cycle keeps the pend set, so it is not lost.
        rd_pend_d = (rd_pend_q && !in_rd) || (spi_read_en_out && !rd_prev_q);
        wr_pend_d = (wr_pend_q && !in_wr) || (spi_write_en_out && !wr_prev_q);
        driver_in_data_d = in_rd ? bank_q[spi_rd_addr] : driver_in_data_q;
        rd_stb_d = in_rd;
        host_rdata_d = (host_ack && !host_we) ? bank_q[host_addr] : host_rdata_q;
        frame_count_d = frame_count_q + 16'(in_wr);
        ro_err_d = ro_err_q || (in_wr && RO_MASK[spi_wr_addr]);
        state_d = state_q;
        cnt_d = cnt_q;
        bank_d = bank_q;
        case (state_q)
            IDLE:      state_d = rd_pend_q ? SPI_RD : wr_pend_q ? SPI_WR : host_req ? HOST : IDLE;
            SPI_RD:    state_d = IDLE;
            SPI_WR: begin
                state_d = FRAME_RST;
                cnt_d = CW'(RST_CYCLES - 1);
            end
            FRAME_RST: begin
                state_d = (cnt_q == '0) ? IDLE : FRAME_RST;
                cnt_d = cnt_q - CW'(1);
            end
            HOST:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (in_wr && !RO_MASK[spi_wr_addr]) bank_d[spi_wr_addr] = driver_out_data;
        if (host_ack && host_we) bank_d[host_addr] = host_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            // Previous-value flops reset high so a level already present at release is not an event.
            rd_prev_q <= 1'b1;
            wr_prev_q <= 1'b1;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            bank_q <= '{default: '0};
            driver_in_data_q <= '0;
            host_rdata_q <= '0;
            rd_stb_q <= 1'b0;
            frame_count_q <= '0;
            ro_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rd_prev_q <= spi_read_en_out;
            wr_prev_q <= spi_write_en_out;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            bank_q <= bank_d;
            driver_in_data_q <= driver_in_data_d;
            host_rdata_q <= host_rdata_d;
            rd_stb_q <= rd_stb_d;
            frame_count_q <= frame_count_d;
            ro_err_q <= ro_err_d;
        end
    end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb_spi_reg_sequencer: randomized self-checking bench for spi_reg_sequencer against a register-bank reference model.
module tb_spi_reg_sequencer;
    localparam int RSTC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_read_en_out = 1'b0, spi_write_en_out = 1'b0;
    logic [3:0]  spi_rd_addr = '0, spi_wr_addr = '0;
    logic [31:0] driver_out_data = '0;
    logic [31:0] driver_in_data;
    logic        spi_read_en_in, spi_frame_rst;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [3:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic [15:0] frame_count;
    logic        ro_err;

    int checks = 0, errors = 0;
    logic [31:0] m_bank [16];
    int unsigned m_fc;
    bit          m_ro;
    logic [15:0] ro_mask_v = 16'h0001;

    spi_reg_sequencer dut (
        .clk(clk), .reset(reset),
        .spi_read_en_out(spi_read_en_out), .spi_write_en_out(spi_write_en_out),
        .spi_rd_addr(spi_rd_addr), .spi_wr_addr(spi_wr_addr),
        .driver_out_data(driver_out_data), .driver_in_data(driver_in_data),
        .spi_read_en_in(spi_read_en_in), .spi_frame_rst(spi_frame_rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .frame_count(frame_count), .ro_err(ro_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_bank[i]) m_bank[i] = '0;
        m_fc = 0;
        m_ro = 0;
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        lat = -1; rd = 'x;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (host_ack) begin
                lat = i;
                rd = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
        if (we) m_bank[a] = d;
        step();
    endtask

    task automatic spi_read(input logic [3:0] a, output int lat, output logic [31:0] d, output int width);
        spi_rd_addr = a; spi_read_en_out = 1'b1;
        lat = -1; d = 'x; width = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (spi_read_en_in) begin
                if (lat < 0) begin
                    lat = i;
                    d = driver_in_data;
                end
                width++;
            end
        end
        spi_read_en_out = 1'b0;
        step();
    endtask

    task automatic spi_write(input logic [3:0] a, input logic [31:0] d, input int hold, output int nrst);
        spi_wr_addr = a; driver_out_data = d; spi_write_en_out = 1'b1; nrst = 0;
        for (int i = 1; i <= hold; i++) begin
            step();
            if (spi_frame_rst) nrst++;
        end
        spi_write_en_out = 1'b0;
        step();
        step();
        if (ro_mask_v[a]) m_ro = 1; else m_bank[a] = d;
        m_fc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (spi_frame_rst !== 1'b1) begin errors++; $display("FAIL reset_frame_rst got %b want 1", spi_frame_rst); end
        reset = 1'b0;
        step();
        model_reset();
        checks++;
        if ({spi_frame_rst, spi_read_en_in, host_ack, ro_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {spi_frame_rst, spi_read_en_in, host_ack, ro_err});
        end
        checks++;
        if (driver_in_data !== 32'h0 || host_rdata !== 32'h0 || frame_count !== 16'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h want 0", driver_in_data, host_rdata, frame_count);
        end
    endtask

    task automatic test_host_rw();
        logic [31:0] rd;
        int lat;
        host_op(1'b1, 4'd3, 32'hDEADBEEF, rd, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL host_wr_lat got %0d want 1", lat); end
        host_op(1'b0, 4'd3, 32'h0, rd, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL host_rd_lat got %0d want 1", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL host_rdata got %h want deadbeef", rd); end
        checks++;
        if (host_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL host_rdata_hold got %h want deadbeef", host_rdata); end
        checks++;
        if (frame_count !== 16'h0) begin errors++; $display("FAIL host_fc got %0d want 0", frame_count); end
    endtask

    task automatic test_spi_read();
        logic [31:0] rd, d;
        int lat, w;
        host_op(1'b1, 4'd5, 32'h12345678, rd, lat);
        spi_read(4'd5, lat, d, w);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL spi_rd_lat got %0d want 3", lat); end
        checks++;
        if (w !== 1) begin errors++; $display("FAIL spi_rd_strobe_width got %0d want 1", w); end
        checks++;
        if (d !== 32'h12345678) begin errors++; $display("FAIL spi_rd_data got %h want 12345678", d); end
    endtask

    task automatic test_spi_write();
        logic [31:0] rd;
        int lat, n;
        spi_write(4'd7, 32'hA5A5A5A5, 12, n);
        checks++;
        if (n !== RSTC) begin errors++; $display("FAIL spi_wr_frame_rst got %0d want %0d", n, RSTC); end
        checks++;
        if (frame_count !== 16'(m_fc)) begin errors++; $display("FAIL spi_wr_fc got %0d want %0d", frame_count, m_fc); end
        host_op(1'b0, 4'd7, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL spi_wr_bank got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_read_only();
        logic [31:0] rd;
        int lat, n;
        spi_write(4'd0, $urandom | 32'h1, 8, n);
        checks++;
        if (ro_err !== 1'b1) begin errors++; $display("FAIL ro_err_set got %b want 1", ro_err); end
        host_op(1'b0, 4'd0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ro_bank got %h want 0", rd); end
        spi_write(4'd9, $urandom, 8, n);
        checks++;
        if (ro_err !== 1'b1) begin errors++; $display("FAIL ro_err_sticky got %b want 1", ro_err); end
        checks++;
        if (frame_count !== 16'(m_fc)) begin errors++; $display("FAIL ro_fc got %0d want %0d", frame_count, m_fc); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [3:0] a;
        int lat, w, n;
        for (int k = 0; k < 40; k++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            case ($urandom_range(0, 3))
                0: host_op(1'b1, a, d, rd, lat);
                1: begin
                    host_op(1'b0, a, d, rd, lat);
                    checks++;
                    if (rd !== m_bank[a]) begin errors++; $display("FAIL rnd_host_rd[%0d] got %h want %h", a, rd, m_bank[a]); end
                end
                2: begin
                    spi_write(a, d, 7, n);
                    checks++;
                    if (frame_count !== 16'(m_fc) || ro_err !== m_ro || n !== RSTC) begin
                        errors++; $display("FAIL rnd_spi_wr got fc=%0d ro=%b rst=%0d want fc=%0d ro=%b rst=%0d",
                                           frame_count, ro_err, n, m_fc, m_ro, RSTC);
                    end
                end
                default: begin
                    spi_read(a, lat, rd, w);
                    checks++;
                    if (rd !== m_bank[a] || lat !== 3 || w !== 1) begin
                        errors++; $display("FAIL rnd_spi_rd[%0d] got %h lat=%0d w=%0d want %h lat=3 w=1", a, rd, lat, w, m_bank[a]);
                    end
                end
            endcase
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, old7, rd;
        int rd_step = -1, fr_first = -1, fr_n = 0, ack_step = -1, ack_n = 0;
        d = $urandom;
        old7 = m_bank[7];
        spi_rd_addr = 4'd7; spi_wr_addr = 4'd2; driver_out_data = d;
        spi_read_en_out = 1'b1; spi_write_en_out = 1'b1;
        host_we = 1'b0; host_addr = 4'd2;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) host_req = 1'b1;
            if (spi_read_en_in && rd_step < 0) begin rd_step = i; rd = driver_in_data; end
            if (spi_frame_rst) begin if (fr_first < 0) fr_first = i; fr_n++; end
            if (host_ack) begin
                ack_n++;
                if (ack_step < 0) begin ack_step = i; host_req = 1'b0; end
                checks++;
                if (host_rdata !== d) begin errors++; $display("FAIL b2b_host_rdata got %h want %h", host_rdata, d); end
            end
        end
        host_req = 1'b0; spi_read_en_out = 1'b0; spi_write_en_out = 1'b0;
        step();
        m_bank[2] = d;
        m_fc++;
        checks++;
        if (rd_step !== 3 || rd !== old7) begin errors++; $display("FAIL b2b_spi_rd got step=%0d data=%h want step=3 data=%h", rd_step, rd, old7); end
        checks++;
        if (fr_first <= rd_step || fr_n !== RSTC) begin errors++; $display("FAIL b2b_frame_rst got first=%0d n=%0d want after %0d n=%0d", fr_first, fr_n, rd_step, RSTC); end
        checks++;
        if (ack_n !== 1 || ack_step !== fr_first + RSTC + 1) begin
            errors++; $display("FAIL b2b_host_ack got n=%0d step=%0d want n=1 step=%0d", ack_n, ack_step, fr_first + RSTC + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, n = 0;
        bit seen = 0;
        reset = 1'b1;
        spi_wr_addr = 4'd4; driver_out_data = 32'hCAFEF00D; spi_write_en_out = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin step(); if (spi_frame_rst) n++; end
        checks++;
        if (n !== 0 || frame_count !== 16'h0) begin errors++; $display("FAIL rst_level_event got rst=%0d fc=%0d want 0 0", n, frame_count); end
        spi_write_en_out = 1'b0;
        step();
        spi_write_en_out = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin step(); seen = spi_frame_rst; end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_mid_frame got no frame_rst want frame_rst"); end
        reset = 1'b1;
        step();
        checks++;
        if (spi_frame_rst !== 1'b1) begin errors++; $display("FAIL rst_mid_frame_rst got %b want 1", spi_frame_rst); end
        step();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin step(); if (spi_frame_rst) n++; end
        checks++;
        if (n !== 0 || frame_count !== 16'h0 || ro_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after got rst=%0d fc=%0d ro=%b want 0 0 0", n, frame_count, ro_err);
        end
        host_op(1'b0, 4'd4, 32'h0, rd, lat);
        checks++;
        if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL rst_mid_idle got lat=%0d rd=%h want 1 0", lat, rd); end
        spi_write_en_out = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_spi_read();
        test_spi_write();
        test_read_only();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
